wb_initiator_fsm: RTL and testbench

- Wishbone B4 classic single-access initiator. It is the master-side counterpart to the wrapper's Wishbone responder port.
- Accepts one read/write command on a valid/ready command channel. Runs exactly one cyc/stb cycle on the bus, then returns data and status on a valid/ready response channel.
- Lets the FSM core, or a test harness, drive a Wishbone responder; a bounded timeout guarantees forward progress.

---
 rtl/wb_initiator_fsm.sv | 144 ++++++++++++++
 tb/tb_wb_initiator_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator_fsm.sv
// Wishbone B4 classic single-access initiator: one command in, one cyc/stb cycle on the bus,
// one response out, with an optional bounded wait for ack/err.
module wb_initiator_fsm #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '1;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              cyc_nx, we_nx;
    logic [3:0]        sel_nx;
    logic [31:0]       adr_nx, dat_o_nx;
    logic              rsp_valid_nx, rsp_err_nx, rsp_timeout_nx;
    logic [31:0]       rsp_dat_nx;
    logic              term;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        cyc_nx         = wbm_cyc_o;
        we_nx          = wbm_we_o;
        sel_nx         = wbm_sel_o;
        adr_nx         = wbm_adr_o;
        dat_o_nx       = wbm_dat_o;
        rsp_valid_nx   = rsp_valid;
        rsp_err_nx     = rsp_err;
        rsp_timeout_nx = rsp_timeout;
        rsp_dat_nx     = rsp_dat;
        term           = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cyc_nx   = 1'b1;
                    we_nx    = cmd_we;
                    sel_nx   = cmd_sel;
                    adr_nx   = cmd_adr;
                    dat_o_nx = cmd_we ? cmd_dat : 32'h0;
                    cnt_nx   = '0;
                    state_nx = BUS;
                end
            end
            BUS: begin
                // err has priority over ack; timeout only when the responder is silent
                if (wbm_err_i) begin
                    term           = 1'b1;
                    rsp_err_nx     = 1'b1;
                    rsp_timeout_nx = 1'b0;
                    rsp_dat_nx     = 32'h0;
                end else if (wbm_ack_i) begin
                    term           = 1'b1;
                    rsp_err_nx     = 1'b0;
                    rsp_timeout_nx = 1'b0;
                    rsp_dat_nx     = wbm_we_o ? 32'h0 : wbm_dat_i;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    term           = 1'b1;
                    rsp_err_nx     = 1'b1;
                    rsp_timeout_nx = 1'b1;
                    rsp_dat_nx     = 32'h0;
                end else if (cnt != CNT_LAST) begin
                    cnt_nx = cnt + 1'b1;
                end

                if (term) begin
                    cyc_nx       = 1'b0;
                    we_nx        = 1'b0;
                    sel_nx       = 4'h0;
                    adr_nx       = 32'h0;
                    dat_o_nx     = 32'h0;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0;
            wbm_dat_o   <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_dat     <= 32'h0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            wbm_cyc_o   <= cyc_nx;
            wbm_stb_o   <= cyc_nx;
            wbm_we_o    <= we_nx;
            wbm_sel_o   <= sel_nx;
            wbm_adr_o   <= adr_nx;
            wbm_dat_o   <= dat_o_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_err     <= rsp_err_nx;
            rsp_timeout <= rsp_timeout_nx;
            rsp_dat     <= rsp_dat_nx;
        end
    end

endmodule

// File: tb/tb_wb_initiator_fsm.sv
// Bench for wb_initiator_fsm: directed vector table, randomized transactions against a
// transaction-level model, and hand sequences for backpressure and reset during a bus cycle.
module tb_wb_initiator_fsm;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err, rsp_timeout;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    int total = 0;
    int bad   = 0;

    wb_initiator_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;   // BUS cycles before the responder answers
        logic        err;     // responder raises err together with ack
        logic [31:0] rdat;
        int          rdly;    // cycles the consumer stalls the response
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        exp_to;
        int          exp_cyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level view: responder answers after `waits` cycles unless the timeout comes first.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.waits < TO) begin
            r.exp_cyc = v.waits + 1;
            r.exp_err = v.err;
            r.exp_to  = 1'b0;
            r.exp_dat = (v.err || v.we) ? 32'h0 : v.rdat;
        end else begin
            r.exp_cyc = TO;
            r.exp_err = 1'b1;
            r.exp_to  = 1'b1;
            r.exp_dat = 32'h0;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int   k;
        int   cycles;
        logic ok;
        logic [31:0] s_dat;
        logic s_err, s_to;
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_dat = $urandom; cmd_adr = $urandom;
        k = 0; cycles = 0; ok = 1'b1;
        while (wbm_cyc_o && k < 40) begin
            cycles++;
            if (wbm_stb_o !== 1'b1 || wbm_adr_o !== v.adr || wbm_we_o !== v.we ||
                wbm_sel_o !== v.sel || wbm_dat_o !== (v.we ? v.dat : 32'h0) ||
                cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
                ok = 1'b0;
            if (k == v.waits) begin
                wbm_ack_i = 1'b1; wbm_err_i = v.err; wbm_dat_i = v.rdat;
            end else begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
            end
            @(posedge clk); #1;
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            k++;
        end
        chk({tag, "_cyc_cycles"}, 32'(cycles), 32'(v.exp_cyc));
        chk({tag, "_bus_stable"}, 32'(ok), 32'h1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_rsp_dat"}, rsp_dat, v.exp_dat);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, "_bus_cleared"}, {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o[25:0]} , 32'h0);
        // stall the consumer while the responder throws late ack/err at an idle bus
        s_dat = rsp_dat; s_err = rsp_err; s_to = rsp_timeout; ok = 1'b1;
        for (int i = 0; i < v.rdly; i++) begin
            wbm_ack_i = 1'b1; wbm_err_i = i[0]; wbm_dat_i = $urandom;
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_dat !== s_dat || rsp_err !== s_err ||
                rsp_timeout !== s_to || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                ok = 1'b0;
        end
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        chk({tag, "_resp_hold"}, 32'(ok), 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_released"}, {rsp_valid, cmd_ready}, 32'h1);
        chk({tag, "_rsp_dat_held"}, rsp_dat, s_dat);
    endtask

    vec_t tbl[5];
    vec_t rv;
    logic [31:0] held_dat;
    logic ok_bp;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

        //          we   adr            dat            sel   w  err  rdat           rdly exp_dat       err  to   cyc
        tbl[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h5555_AAAA, 2, 32'h0,        1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 32'h3000_0010, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0, 1'b0, 4};
        tbl[2] = '{1'b0, 32'h0000_0100, 32'h0,         4'h3, 1, 1'b1, 32'hCAFE_F00D, 0, 32'h0,        1'b1, 1'b0, 2};
        tbl[3] = '{1'b0, 32'h8000_0000, 32'h0,         4'hC, 9, 1'b0, 32'hABCD_0123, 3, 32'h0,        1'b1, 1'b1, 4};
        tbl[4] = '{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'h1, 2, 1'b1, 32'h7777_7777, 1, 32'h0,        1'b1, 1'b0, 3};

        #12;
        chk("reset_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'h0);
        chk("reset_adr_dat", wbm_adr_o | wbm_dat_o, 32'h0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 32'h1);
        chk("reset_rsp_dat", rsp_dat, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rv.we = $urandom_range(0, 1); rv.adr = $urandom; rv.dat = $urandom;
            rv.sel = 4'($urandom); rv.waits = $urandom_range(0, 6);
            rv.err = ($urandom_range(0, 3) == 0); rv.rdat = $urandom; rv.rdly = $urandom_range(0, 3);
            rv = model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // backpressure with cmd_valid held high across the whole response phase
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h4000_0000; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_adr = 32'h4000_0008; cmd_we = 1'b0;
        wbm_ack_i = 1'b1;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        held_dat = rsp_dat; ok_bp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 ||
                rsp_dat !== held_dat || rsp_err !== 1'b0) ok_bp = 1'b0;
        end
        chk("bp_hold", 32'(ok_bp), 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_no_accept_on_handshake", {rsp_valid, cmd_ready, wbm_cyc_o}, 32'h2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_second_accept", {wbm_cyc_o, wbm_stb_o}, 32'h3);
        chk("bp_second_adr", wbm_adr_o, 32'h4000_0008);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        chk("bp_second_rsp", rsp_dat, 32'h9ABC_DEF0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // reset during a wait-stated read
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h5000_0000; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_cyc", {wbm_cyc_o, wbm_stb_o}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {wbm_cyc_o, wbm_stb_o, rsp_valid}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_release", {rsp_valid, cmd_ready, wbm_cyc_o}, 32'h2);

        rv = '{1'b0, 32'h6000_0020, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D, 1, 32'h0, 1'b0, 1'b0, 0};
        run_txn(model(rv), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
